// File: rtl/dff_rr_share_arb.sv
// Round-robin arbiter sharing one data register among NUM_REQ requesters.
// Define ARB_HOLD_LIMIT_EN to force a handoff after MAX_HOLD owned cycles when others wait.
//
// state | meaning
// IDLE  | no owner; gnt=0, q_valid=0, q and owner_id hold their last values
// OWN   | owner_id holds the register and writes wdata[owner_id] each cycle
module dff_rr_share_arb #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      sync_reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ID_W-1:0]           owner_id,
  output logic [DATA_W-1:0]         q,
  output logic                      q_valid
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     ptr, ptr_nxt;
  logic [ID_W-1:0]     winner;
  logic                found;
  int                  cand;
  logic                grant;
  logic [NUM_REQ-1:0]  gnt_nxt;
  logic [ID_W-1:0]     id_nxt;
  logic [DATA_W-1:0]   q_nxt;
  logic                qv_nxt;

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  logic [7:0] hold_cnt, hold_nxt;
`endif

  // Search starts at ptr and wraps; while owning, the current owner is skipped
  // so that "found" also means "someone else is waiting".
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[cand] && !(state == OWN && cand == int'(owner_id))) begin
        found  = 1'b1;
        winner = ID_W'(cand);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    id_nxt    = owner_id;
    q_nxt     = q;
    qv_nxt    = q_valid;
    ptr_nxt   = ptr;
    grant     = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_nxt  = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (found) grant = 1'b1;
      end
      OWN: begin
        if (!req[owner_id]) begin
          if (found) begin
            grant = 1'b1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            qv_nxt    = 1'b0;
          end
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (hold_cnt == HOLD_MAX && found) begin
          grant = 1'b1;
        end
`endif
        else begin
          q_nxt = wdata[owner_id*DATA_W +: DATA_W];
`ifdef ARB_HOLD_LIMIT_EN
          if (hold_cnt < HOLD_MAX) hold_nxt = hold_cnt + 8'd1;
`endif
        end
      end
    endcase

    if (grant) begin
      state_nxt = OWN;
      gnt_nxt   = NUM_REQ'(1) << winner;
      id_nxt    = winner;
      q_nxt     = wdata[winner*DATA_W +: DATA_W];
      qv_nxt    = 1'b1;
      ptr_nxt   = ID_W'((int'(winner) + 1) % NUM_REQ);
`ifdef ARB_HOLD_LIMIT_EN
      hold_nxt  = 8'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state    <= IDLE;
      gnt      <= '0;
      owner_id <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      ptr      <= '0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      owner_id <= id_nxt;
      q        <= q_nxt;
      q_valid  <= qv_nxt;
      ptr      <= ptr_nxt;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt <= hold_nxt;
`endif
    end
  end

endmodule
